// File: rtl/vslc_scan_sequencer.sv
// vslc_scan_sequencer
// Instruction-feed stage in front of the VSLC executor. A byte-wide program
// memory is loaded serially, then executed as a cyclic scan:
//   SNAP (one bubble cycle: capture inputs) followed by prog_len EXEC cycles
//   (one instruction per cycle). The input snapshot stays constant for the
//   whole scan, so executor edge detection is scan-coherent.
//
// Optional build macro: VSLC_SCAN_STEP_EN adds a 'step' input. When defined,
// EXEC issues only on cycles with step=1; SNAP still advances without it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_start         pulse, start a program load (IDLE only)
//   load_valid/byte    program byte offer
//   load_ready         sequencer can store a byte this cycle
//   load_done          pulse, end of load (latches prog_len)
//   load_ovf           sticky, a byte was offered while memory was full
//   run_en             level, keep scanning
//   ui_in_raw          live external inputs
//   instr/instr_ready  instruction to executor (instr=0 when not ready)
//   ui_in/ui_in_prev   current / previous scan input snapshot
//   scan_done          pulse with the last instruction of a scan
//   prog_len           number of loaded bytes
//   pc                 address of the next instruction to fetch
//   state_dbg          current FSM state (IDLE=0, LOAD=1, SNAP=2, EXEC=3)
//   step               (VSLC_SCAN_STEP_EN only) issue enable for EXEC
//
// Load handshake: a byte is stored on a clock edge where the FSM is in LOAD,
// load_valid=1 and load_ready=1. load_ready is registered and falls on the
// edge that stores the final free slot. Offers while not ready are dropped
// and flag load_ovf.
module vslc_scan_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_done,
  output logic              load_ovf,
  input  logic              run_en,
  input  logic [7:0]        ui_in_raw,
  output logic [7:0]        instr,
  output logic              instr_ready,
  output logic [7:0]        ui_in,
  output logic [7:0]        ui_in_prev,
  output logic              scan_done,
  output logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state_dbg
`ifdef VSLC_SCAN_STEP_EN
  ,
  input  logic              step
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SNAP = 2'd2,
    EXEC = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   WADDR_ONE = 1;
  localparam logic [ADDR_W-1:0] PC_ONE    = 1;

  state_t            state;
  logic [7:0]        mem [PROG_DEPTH];
  logic [ADDR_W:0]   waddr;
  logic [ADDR_W:0]   waddr_inc;
  logic              mem_full;
  logic              mem_we;
  logic              last_instr;
  logic              issue;

  // waddr never exceeds PROG_DEPTH (a power of two), so its top bit is "full".
  assign mem_full   = waddr[ADDR_W];
  assign waddr_inc  = waddr + WADDR_ONE;
  assign mem_we     = !rst && (state == LOAD) && load_valid && !mem_full;
  // Only evaluated in EXEC, where prog_len is at least 1.
  assign last_instr = ({1'b0, pc} == (prog_len - WADDR_ONE));
  assign state_dbg  = state;

`ifdef VSLC_SCAN_STEP_EN
  assign issue = step;
`else
  assign issue = 1'b1;
`endif

  // Program memory is deliberately not reset; prog_len=0 makes it inert.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr[ADDR_W-1:0]] <= load_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      waddr       <= '0;
      prog_len    <= '0;
      pc          <= '0;
      instr       <= 8'h00;
      instr_ready <= 1'b0;
      ui_in       <= 8'h00;
      ui_in_prev  <= 8'h00;
      scan_done   <= 1'b0;
      load_ready  <= 1'b0;
      load_ovf    <= 1'b0;
    end else begin
      // Issue outputs are single-cycle unless EXEC re-asserts them.
      instr       <= 8'h00;
      instr_ready <= 1'b0;
      scan_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            waddr      <= '0;
            load_ovf   <= 1'b0;
            load_ready <= 1'b1;
          end else if (run_en && (prog_len != '0)) begin
            state <= SNAP;
          end
        end
        LOAD: begin
          if (mem_we) begin
            waddr <= waddr_inc;
          end
          if (load_valid && mem_full) begin
            load_ovf <= 1'b1;
          end
          if (load_done) begin
            // A byte stored on the same edge as load_done is counted.
            prog_len   <= mem_we ? waddr_inc : waddr;
            load_ready <= 1'b0;
            state      <= IDLE;
          end else begin
            load_ready <= mem_we ? !waddr_inc[ADDR_W] : !mem_full;
          end
        end
        SNAP: begin
          ui_in_prev <= ui_in;
          ui_in      <= ui_in_raw;
          pc         <= '0;
          state      <= EXEC;
        end
        EXEC: begin
          if (issue) begin
            instr       <= mem[pc];
            instr_ready <= 1'b1;
            pc          <= pc + PC_ONE;
            if (last_instr) begin
              // run_en is only sampled here, so scans always complete.
              scan_done <= 1'b1;
              state     <= run_en ? SNAP : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
